// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch/exception redirect controller.
// Holds the controller state encoding, the redirect request shape and the idle redirect address.
package branch_redirect_ctrl_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DS  = 2'd1,
        REDIRECT = 2'd2
    } redirect_state_t;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
    } redirect_req_t;

    // Value driven on redirect_pc whenever no redirect is being requested.
    localparam logic [PC_W-1:0] RESET_PC = '0;

    function automatic logic is_resolve(input logic exe_valid,
                                        input logic br_taken,
                                        input logic exe_stall);
        return exe_valid & br_taken & ~exe_stall;
    endfunction

endpackage

// File: rtl/redirect_perf_cnt.sv
// Wrapping event counters for the redirect controller: branch handshakes, delay-slot wait
// cycles and exception handshakes. Only instantiated when BRANCH_REDIRECT_PERF_EN is defined.
module redirect_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              br_hs,
    input  logic              exc_hs,
    input  logic              ds_wait,
    output logic [PERF_W-1:0] perf_br_redirects,
    output logic [PERF_W-1:0] perf_ds_wait_cycles,
    output logic [PERF_W-1:0] perf_exc_redirects
);

    logic [PERF_W-1:0] br_cnt_q,  br_cnt_d;
    logic [PERF_W-1:0] ds_cnt_q,  ds_cnt_d;
    logic [PERF_W-1:0] exc_cnt_q, exc_cnt_d;

    always_comb begin
        br_cnt_d  = br_hs   ? br_cnt_q  + PERF_W'(1) : br_cnt_q;
        ds_cnt_d  = ds_wait ? ds_cnt_q  + PERF_W'(1) : ds_cnt_q;
        exc_cnt_d = exc_hs  ? exc_cnt_q + PERF_W'(1) : exc_cnt_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_cnt_q  <= '0;
            ds_cnt_q  <= '0;
            exc_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            ds_cnt_q  <= ds_cnt_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

    assign perf_br_redirects   = br_cnt_q;
    assign perf_ds_wait_cycles = ds_cnt_q;
    assign perf_exc_redirects  = exc_cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: waits for the branch delay slot, holds the fetch redirect until
// accepted, lets MEM exceptions override. Optional counters under BRANCH_REDIRECT_PERF_EN.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              exe_valid,
    input  logic              exe_stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              ds_in_id,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              redirect_ready,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if,
    output logic              flush_all,
    output logic              busy
`ifdef BRANCH_REDIRECT_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_br_redirects,
    output logic [PERF_W-1:0] perf_ds_wait_cycles,
    output logic [PERF_W-1:0] perf_exc_redirects
`endif
);

    localparam logic [ADDR_W-1:0] IDLE_PC = ADDR_W'(RESET_PC);

    redirect_state_t   state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_if_q, flush_if_d;
    logic              flush_all_q, flush_all_d;
    logic              busy_q, busy_d;
    logic              is_exc_q, is_exc_d;

    logic resolve;
    logic handshake;

    assign resolve   = is_resolve(exe_valid, br_taken, exe_stall);
    assign handshake = valid_q & redirect_ready;

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        is_exc_d    = is_exc_q;
        flush_all_d = 1'b0;

        if (exc_valid) begin
            // Exception wins over everything, including a resolve in the same cycle.
            state_d     = REDIRECT;
            valid_d     = 1'b1;
            pc_d        = exc_pc;
            is_exc_d    = 1'b1;
            flush_all_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (resolve) begin
                        if (ds_in_id) begin
                            state_d  = REDIRECT;
                            valid_d  = 1'b1;
                            pc_d     = br_target;
                            is_exc_d = 1'b0;
                        end else begin
                            state_d  = WAIT_DS;
                            target_d = br_target;
                        end
                    end
                end
                WAIT_DS: begin
                    if (ds_in_id) begin
                        state_d  = REDIRECT;
                        valid_d  = 1'b1;
                        pc_d     = target_q;
                        is_exc_d = 1'b0;
                    end
                end
                REDIRECT: begin
                    // Resolves outside the handshake cycle are wrong-path and dropped.
                    if (handshake) begin
                        is_exc_d = 1'b0;
                        if (resolve && ds_in_id) begin
                            state_d = REDIRECT;
                            valid_d = 1'b1;
                            pc_d    = br_target;
                        end else if (resolve) begin
                            state_d  = WAIT_DS;
                            target_d = br_target;
                            valid_d  = 1'b0;
                            pc_d     = IDLE_PC;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            pc_d    = IDLE_PC;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    pc_d    = IDLE_PC;
                end
            endcase
        end

        flush_if_d = (state_d == REDIRECT);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            target_q    <= IDLE_PC;
            valid_q     <= 1'b0;
            pc_q        <= IDLE_PC;
            flush_if_q  <= 1'b0;
            flush_all_q <= 1'b0;
            busy_q      <= 1'b0;
            is_exc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            flush_if_q  <= flush_if_d;
            flush_all_q <= flush_all_d;
            busy_q      <= busy_d;
            is_exc_q    <= is_exc_d;
        end
    end

    assign redirect_valid = valid_q;
    assign redirect_pc    = pc_q;
    assign flush_if       = flush_if_q;
    assign flush_all      = flush_all_q;
    assign busy           = busy_q;

`ifdef BRANCH_REDIRECT_PERF_EN
    redirect_perf_cnt #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk                 (clk),
        .resetn              (resetn),
        .br_hs               (handshake & ~is_exc_q),
        .exc_hs              (handshake &  is_exc_q),
        .ds_wait             (state_q == WAIT_DS),
        .perf_br_redirects   (perf_br_redirects),
        .perf_ds_wait_cycles (perf_ds_wait_cycles),
        .perf_exc_redirects  (perf_exc_redirects)
    );
`endif

endmodule
